// File: rtl/cp0.sv
// cp0 - CPU-side coprocessor 0.
// Latches the device interrupt lines, holds SR / Cause / EPC / PRId and raises
// a trap request to the pipeline for enabled interrupts or internal exceptions.
// On trap entry the victim PC and cause are saved; eret (i_exl_clr) returns to RUN.
//
// Ports
//   i_clk       system clock, all state updates on posedge
//   i_reset     asynchronous active-high reset
//   i_a1        mfc0 read register number
//   i_a2        mtc0 write register number
//   i_din       mtc0 write data
//   i_we        mtc0 write enable
//   i_pc        PC of the M-stage instruction
//   i_bd_in     M-stage instruction sits in a branch delay slot
//   i_exc_code  internal exception code, 0 = none
//   i_exl_clr   eret in the M stage
//   i_hw_int    device interrupt lines, bit 0 is the timer
//   o_req       trap now (combinational)
//   o_epc       current EPC value
//   o_dout      mfc0 read data (combinational on i_a1)
//
// state   | meaning
// --------+---------------------------------------------
// RUN     | EXL=0, traps may be taken
// HANDLER | EXL=1, inside the handler, traps suppressed

module cp0 #(
    parameter logic [31:0] PRID = 32'h5345_5500
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_a1,
    input  logic [4:0]  i_a2,
    input  logic [31:0] i_din,
    input  logic        i_we,
    input  logic [31:0] i_pc,
    input  logic        i_bd_in,
    input  logic [4:0]  i_exc_code,
    input  logic        i_exl_clr,
    input  logic [5:0]  i_hw_int,
    output logic        o_req,
    output logic [31:0] o_epc,
    output logic [31:0] o_dout
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // The state encoding is the EXL bit itself.
    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      r_state;
    logic [5:0]  r_im;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;

    state_t      w_state_nxt;
    logic [5:0]  w_im_nxt;
    logic        w_ie_nxt;
    logic        w_bd_nxt;
    logic [4:0]  w_exc_nxt;
    logic [31:0] w_epc_nxt;

    logic        w_exl;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_sr_we;
    logic        w_epc_we;
    logic [31:0] w_victim;
    logic        w_unused;

    assign w_exl     = (r_state == HANDLER);
    // Live i_hw_int (not r_ip) so an interrupt traps in the cycle it arrives.
    assign w_int_req = r_ie & ~w_exl & (|(i_hw_int & r_im));
    assign w_exc_req = ~w_exl & (i_exc_code != 5'd0);
    assign w_req     = w_int_req | w_exc_req;
    assign o_req     = w_req;
    assign o_epc     = r_epc;

    // A trapping instruction is flushed, so its mtc0 must not land.
    assign w_sr_we   = i_we & (i_a2 == REG_SR)  & ~w_req;
    assign w_epc_we  = i_we & (i_a2 == REG_EPC) & ~w_req;
    assign w_victim  = i_bd_in ? (i_pc - 32'd4) : i_pc;

    assign w_unused  = ^{i_din[31:16], i_din[9:2]};

    always_comb begin
        w_state_nxt = r_state;
        w_im_nxt    = r_im;
        w_ie_nxt    = r_ie;
        w_bd_nxt    = r_bd;
        w_exc_nxt   = r_exc;
        w_epc_nxt   = r_epc;

        if (w_sr_we) begin
            w_im_nxt    = i_din[15:10];
            w_ie_nxt    = i_din[0];
            w_state_nxt = i_din[1] ? HANDLER : RUN;
        end
        if (w_epc_we) begin
            w_epc_nxt = {i_din[31:2], 2'b00};
        end

        // eret beats a simultaneous SR write on the EXL bit only.
        case (r_state)
            RUN: begin
                if (w_req) begin
                    w_state_nxt = HANDLER;
                    w_bd_nxt    = i_bd_in;
                    w_epc_nxt   = {w_victim[31:2], 2'b00};
                    w_exc_nxt   = w_int_req ? 5'd0 : i_exc_code;
                end
            end
            HANDLER: begin
                if (i_exl_clr) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RUN;
            r_im    <= 6'd0;
            r_ie    <= 1'b0;
            r_bd    <= 1'b0;
            r_ip    <= 6'd0;
            r_exc   <= 5'd0;
            r_epc   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_im    <= w_im_nxt;
            r_ie    <= w_ie_nxt;
            r_bd    <= w_bd_nxt;
            r_ip    <= i_hw_int;
            r_exc   <= w_exc_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    always_comb begin
        o_dout = 32'd0;
        case (i_a1)
            REG_SR:    o_dout = {16'd0, r_im, 8'd0, w_exl, r_ie};
            REG_CAUSE: o_dout = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'b00};
            REG_EPC:   o_dout = r_epc;
            REG_PRID:  o_dout = PRID;
            default:   o_dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2, exc_code;
    logic [31:0] din, pc;
    logic        we, bd_in, exl_clr;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc, dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cp0 dut (
        .i_clk(clk), .i_reset(reset), .i_a1(a1), .i_a2(a2), .i_din(din),
        .i_we(we), .i_pc(pc), .i_bd_in(bd_in), .i_exc_code(exc_code),
        .i_exl_clr(exl_clr), .i_hw_int(hw_int),
        .o_req(req), .o_epc(epc), .o_dout(dout)
    );

    // sel: 0 = req, 1 = epc output, 2 = dout with a1 = reg
    typedef struct {
        string       name;
        int          sel;
        logic [4:0]  reg_n;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic [4:0]  reg_n;
        logic [31:0] exp;
    } vec_t;

    vec_t reset_vecs[7];

    task automatic push(input string name, input int sel, input logic [4:0] reg_n,
                        input logic [31:0] exp);
        exp_t e;
        e.name = name; e.sel = sel; e.reg_n = reg_n; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel == 2) a1 = e.reg_n;
            #1;
            case (e.sel)
                0:       act = {31'd0, req};
                1:       act = epc;
                default: act = dout;
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; a2 = 0; din = 0; exl_clr = 0; exc_code = 0; bd_in = 0;
    endtask

    initial begin
        reset = 1; a1 = 0; pc = 0; hw_int = 0;
        idle_inputs();

        reset_vecs[0] = '{"rst_sr",    5'd12, 32'h0};
        reset_vecs[1] = '{"rst_cause", 5'd13, 32'h0};
        reset_vecs[2] = '{"rst_epc",   5'd14, 32'h0};
        reset_vecs[3] = '{"rst_prid",  5'd15, 32'h5345_5500};
        reset_vecs[4] = '{"rst_reg3",  5'd3,  32'h0};
        reset_vecs[5] = '{"rst_reg0",  5'd0,  32'h0};
        reset_vecs[6] = '{"rst_reg31", 5'd31, 32'h0};

        #12;
        push("rst_req_in_reset", 0, 0, 32'd0);
        sb_check();
        reset = 0;
        step();
        for (int i = 0; i < 7; i++)
            push(reset_vecs[i].name, 2, reset_vecs[i].reg_n, reset_vecs[i].exp);
        push("rst_req", 0, 0, 32'd0);
        sb_check();

        // mtc0 SR=0x401; same-cycle read returns the old value
        we = 1; a2 = 12; din = 32'h0000_0401;
        push("sr_read_old", 2, 12, 32'h0);
        sb_check();
        step();
        we = 0;
        push("sr_written", 2, 12, 32'h0000_0401);
        sb_check();

        // EPC write stores bits [1:0] as zero; Cause write discarded
        we = 1; a2 = 14; din = 32'h0000_1237;
        step();
        a2 = 13; din = 32'hFFFF_FFFF;
        step();
        we = 0;
        push("epc_low_bits", 2, 14, 32'h0000_1234);
        push("cause_ro", 2, 13, 32'h0);
        sb_check();

        // timer interrupt, 0-cycle Req, then trap entry
        hw_int = 6'b000001; pc = 32'h0000_3010;
        push("int_req_same_cycle", 0, 0, 32'd1);
        sb_check();
        step();
        push("int_epc", 1, 0, 32'h0000_3010);
        push("int_cause", 2, 13, 32'h0000_0400);
        push("int_sr_exl", 2, 12, 32'h0000_0403);
        push("int_req_suppressed", 0, 0, 32'd0);
        sb_check();
        hw_int = 0; exl_clr = 1;
        step();
        exl_clr = 0;
        push("eret_sr", 2, 12, 32'h0000_0401);
        push("eret_req", 0, 0, 32'd0);
        sb_check();

        // interrupt in a branch delay slot
        hw_int = 6'b000001; pc = 32'h0000_3024; bd_in = 1;
        step();
        bd_in = 0;
        push("bd_epc", 1, 0, 32'h0000_3020);
        push("bd_cause", 2, 13, 32'h8000_0400);
        sb_check();
        hw_int = 0; exl_clr = 1;
        step();
        exl_clr = 0;

        // internal exception with IE=0
        we = 1; a2 = 12; din = 32'h0;
        step();
        we = 0; exc_code = 5'd4; pc = 32'h0000_3008;
        push("exc_req", 0, 0, 32'd1);
        sb_check();
        step();
        exc_code = 5'd10;
        push("exc_cause", 2, 13, 32'h0000_0010);
        push("exc_epc", 1, 0, 32'h0000_3008);
        push("exc_in_handler_req", 0, 0, 32'd0);
        sb_check();
        step();
        push("exc_cause_hold", 2, 13, 32'h0000_0010);
        sb_check();
        exc_code = 0; exl_clr = 1;
        step();
        exl_clr = 0;

        // trap wins over simultaneous mtc0 EPC; pending int after eret
        we = 1; a2 = 12; din = 32'h0000_0401;
        step();
        a2 = 14; din = 32'h0000_1234; hw_int = 6'b000001; pc = 32'h0000_3040;
        push("trap_vs_mtc0_req", 0, 0, 32'd1);
        sb_check();
        step();
        we = 0;
        push("trap_vs_mtc0_epc", 1, 0, 32'h0000_3040);
        sb_check();
        exl_clr = 1;
        push("eret_cycle_req", 0, 0, 32'd0);
        sb_check();
        step();
        exl_clr = 0;
        push("pending_after_eret", 0, 0, 32'd1);
        sb_check();
        hw_int = 0;

        // eret and mtc0 SR together: EXL cleared, other fields from DIn
        hw_int = 6'b000001; pc = 32'h0000_3050;
        step();
        hw_int = 0; exl_clr = 1; we = 1; a2 = 12; din = 32'h0000_FC03;
        step();
        exl_clr = 0; we = 0;
        push("eret_with_sr_write", 2, 12, 32'h0000_FC01);
        sb_check();

        // asynchronous reset mid-handler
        hw_int = 6'b100000; pc = 32'h0000_3060;
        step();
        hw_int = 0;
        push("pre_reset_epc", 1, 0, 32'h0000_3060);
        sb_check();
        @(posedge clk);
        #2 reset = 1;
        push("async_rst_sr", 2, 12, 32'h0);
        push("async_rst_cause", 2, 13, 32'h0);
        push("async_rst_epc", 1, 0, 32'h0);
        push("async_rst_req", 0, 0, 32'd0);
        sb_check();
        reset = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
